mem_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing the single-port 256x16 mem between N_REQ requesters.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_REQ requesters.
// Optional build macro MEM_ARB_HIPRI_EN gives requester 0 fixed top priority.
module mem_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cur;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt_ptr;
  logic          any;
  logic          keep_ptr;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin : pick
    int idx;
    idx      = 0;
    win      = '0;
    any      = 1'b0;
    keep_ptr = 1'b0;
`ifdef MEM_ARB_HIPRI_EN
    if (req[0]) begin
      any      = 1'b1;
      keep_ptr = 1'b1;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
    nxt_ptr = (int'(win) == N_REQ - 1) ? '0 : win + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur       <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            gnt[win]  <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= req_we[win];
            mem_addr  <= req_addr[win*AW +: AW];
            mem_wdata <= req_wdata[win*DW +: DW];
            cur       <= win;
            if (!keep_ptr) rr_ptr <= nxt_ptr;
          end
        end
        ISSUE: begin
          // Address/data/we stay put; only the strobe drops.
          mem_en <= 1'b0;
          if (mem_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          rdata       <= mem_rdata;
          rvalid[cur] <= 1'b1;
          state       <= IDLE;
          busy        <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-requester op queues drive req, a reference memory
// predicts read data, and an expected-read queue is checked against rvalid/rdata.
module tb_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [DW-1:0]     rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              busy;

  mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port memory: read data valid one cycle after the strobe.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
  typedef struct { int id; logic [DW-1:0] data; int due; } exp_t;

  op_t           q0[$];
  op_t           q1[$];
  exp_t          exp_q[$];
  int            gnt_log[$];
  int            gcyc_log[$];
  logic [DW-1:0] ref_mem [256];
  int            chk_cnt = 0;
  int            pass_cnt = 0;
  int            cyc;

  task automatic push_op(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    if (id == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  task automatic drive_reqs();
    req = '0;
    if (q0.size() > 0) begin
      req[0] = 1'b1; req_we[0] = q0[0].we;
      req_addr[AW-1:0] = q0[0].addr; req_wdata[DW-1:0] = q0[0].data;
    end
    if (q1.size() > 0) begin
      req[1] = 1'b1; req_we[1] = q1[0].we;
      req_addr[2*AW-1:AW] = q1[0].addr; req_wdata[2*DW-1:DW] = q1[0].data;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Plays the queued ops as held requests until everything has drained.
  task automatic run(input int budget);
    logic         prev_en;
    logic         got;
    logic [N-1:0] exp_rv;
    int           id;
    int           done;
    op_t          o;
    exp_t         e;
    gnt_log.delete(); gcyc_log.delete();
    cyc = 0; prev_en = 1'b0; done = 0;
    @(negedge clk);
    drive_reqs();
    while (done == 0) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        id = gnt[1] ? 1 : 0;
        got = 1'b0;
        if (id == 0 && q0.size() > 0) begin o = q0.pop_front(); got = 1'b1; end
        else if (id == 1 && q1.size() > 0) begin o = q1.pop_front(); got = 1'b1; end
        chk_cnt++;
        if (!$onehot(gnt) || !got)
          $display("FAIL gnt_valid cyc=%0d gnt=%b pending0=%0d pending1=%0d", cyc, gnt, q0.size(), q1.size());
        else pass_cnt++;
        if (got) begin
          chk_cnt++;
          if ({mem_en, mem_we, mem_addr} !== {1'b1, o.we, o.addr} || (o.we && mem_wdata !== o.data))
            $display("FAIL mem_port cyc=%0d got en=%b we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                     cyc, mem_en, mem_we, mem_addr, mem_wdata, o.we, o.addr, o.data);
          else pass_cnt++;
          gnt_log.push_back(id);
          gcyc_log.push_back(cyc);
          if (o.we) ref_mem[o.addr] = o.data;
          else begin
            e.id = id; e.data = ref_mem[o.addr]; e.due = cyc + 2;
            exp_q.push_back(e);
          end
        end
      end
      if (rvalid != '0) begin
        chk_cnt++;
        if (exp_q.size() == 0)
          $display("FAIL rvalid_spurious cyc=%0d rvalid=%b rdata=%h", cyc, rvalid, rdata);
        else begin
          e = exp_q.pop_front();
          exp_rv = '0; exp_rv[e.id] = 1'b1;
          if ({rvalid, rdata} !== {exp_rv, e.data} || cyc != e.due)
            $display("FAIL read_data cyc=%0d rvalid=%b rdata=%h want cyc=%0d rvalid=%b rdata=%h",
                     cyc, rvalid, rdata, e.due, exp_rv, e.data);
          else pass_cnt++;
        end
      end
      if (mem_en) begin
        chk_cnt++;
        if (prev_en) $display("FAIL mem_en_b2b cyc=%0d got back-to-back strobe want gap", cyc);
        else pass_cnt++;
      end
      prev_en = mem_en;
      drive_reqs();
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !busy) done = 1;
      if (done == 0 && cyc >= budget) begin
        chk_cnt++;
        $display("FAIL run_timeout cyc=%0d pending0=%0d pending1=%0d reads=%0d", cyc, q0.size(), q1.size(), exp_q.size());
        q0.delete(); q1.delete(); exp_q.delete();
        done = 1;
      end
    end
    req = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({gnt, rvalid, mem_en, mem_we, busy} !== '0)
      $display("FAIL reset_ctrl gnt=%b rvalid=%b en=%b we=%b busy=%b want all 0", gnt, rvalid, mem_en, mem_we, busy);
    else pass_cnt++;
    chk_cnt++;
    if ({rdata, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr, mem_wdata);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    do_reset();
    push_op(0, 1'b1, 8'h10, 16'h1234);
    push_op(0, 1'b0, 8'h10, 16'h0000);
    run(40);
    chk_cnt++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 0 || gcyc_log[0] != 1 || gcyc_log[1] != 3)
      $display("FAIL wr_rd_timing got %0d grants first_cyc=%0d want grants to 0 at cyc 1,3",
               gnt_log.size(), (gcyc_log.size() > 0) ? gcyc_log[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_simul_write();
    int want1;
`ifdef MEM_ARB_HIPRI_EN
    want1 = 0;
`else
    want1 = 1;
`endif
    do_reset();
    push_op(0, 1'b1, 8'h20, 16'hABCD);
    push_op(1, 1'b1, 8'h21, 16'h5555);
    push_op(0, 1'b0, 8'h20, 16'h0000);
    push_op(1, 1'b0, 8'h21, 16'h0000);
    run(60);
    chk_cnt++;
    if (gnt_log.size() != 4 || gnt_log[0] != 0 || gnt_log[1] != want1)
      $display("FAIL simul_order got n=%0d first=%0d second=%0d want 4 grants 0 then %0d",
               gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1, (gnt_log.size() > 1) ? gnt_log[1] : -1, want1);
    else pass_cnt++;
  endtask

  task automatic test_rr_reads();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_op(0, 1'b0, 8'h20, 16'h0000);
      push_op(1, 1'b0, 8'h21, 16'h0000);
    end
    run(80);
    chk_cnt++;
    if (gnt_log.size() != 8) $display("FAIL rr_count got %0d grants want 8", gnt_log.size());
    else pass_cnt++;
    for (int i = 0; i < gnt_log.size(); i++) begin
      chk_cnt++;
      if (gnt_log[i] != i % 2 || gcyc_log[i] != 1 + 3 * i)
        $display("FAIL rr_grant%0d got id=%0d cyc=%0d want id=%0d cyc=%0d", i, gnt_log[i], gcyc_log[i], i % 2, 1 + 3 * i);
      else pass_cnt++;
    end
  endtask

`ifdef MEM_ARB_HIPRI_EN
  task automatic test_hipri();
    do_reset();
    for (int i = 0; i < 3; i++) push_op(0, 1'b0, 8'h20, 16'h0000);
    for (int i = 0; i < 2; i++) push_op(1, 1'b0, 8'h21, 16'h0000);
    run(60);
    chk_cnt++;
    if (gnt_log.size() != 5 || gnt_log[0] != 0 || gnt_log[1] != 0 || gnt_log[2] != 0 || gnt_log[3] != 1 || gnt_log[4] != 1)
      $display("FAIL hipri_order got n=%0d want 0,0,0,1,1", gnt_log.size());
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk);
    req = 2'b01; req_we = 2'b00; req_addr[AW-1:0] = 8'h20;
    @(negedge clk);
    req = '0;
    chk_cnt++;
    if (gnt !== 2'b01) $display("FAIL midrd_gnt got %b want 01", gnt);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b1 || mem_en !== 1'b0) $display("FAIL midrd_rdwait busy=%b en=%b want 1/0", busy, mem_en);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_cnt++;
    if ({rvalid, busy, mem_en} !== '0 || mem_addr !== '0 || rdata !== '0)
      $display("FAIL midrd_reset rvalid=%b busy=%b en=%b addr=%h rdata=%h want 0", rvalid, busy, mem_en, mem_addr, rdata);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (rvalid !== '0 || busy !== 1'b0) $display("FAIL midrd_after%0d rvalid=%b busy=%b want 0", i, rvalid, busy);
      else pass_cnt++;
    end
    // rr_ptr was 1 before reset; both requesting now must pick 0.
    push_op(0, 1'b1, 8'h30, 16'h0F0F);
    push_op(1, 1'b1, 8'h31, 16'hF0F0);
    run(40);
    chk_cnt++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0)
      $display("FAIL midrd_rrptr got n=%0d first=%0d want first grant 0", gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_idle();
    req = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({mem_en, busy, gnt} !== '0) $display("FAIL idle%0d en=%b busy=%b gnt=%b want 0", i, mem_en, busy, gnt);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_simul_write();
`ifndef MEM_ARB_HIPRI_EN
    test_rr_reads();
`else
    test_hipri();
`endif
    test_reset_mid_read();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
